// File: rtl/dso_cap_pkg.sv
// Shared types and constants for the DSO trigger-and-capture engine.
package dso_cap_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_FILL,
    ST_WAIT,
    ST_POST,
    ST_FLUSH
  } cap_state_t;

  localparam logic [1:0] TRIG_RISE  = 2'd0;
  localparam logic [1:0] TRIG_FALL  = 2'd1;
  localparam logic [1:0] TRIG_BOTH  = 2'd2;
  localparam logic [1:0] TRIG_FORCE = 2'd3;

  function automatic int calc_pack(input int out_w, input int ch_num, input int smp_w);
    return out_w / (ch_num * smp_w);
  endfunction

endpackage

// File: rtl/dso_ring_ram.sv
// Simple dual-port synchronous RAM: one write port, one registered read port.
module dso_ring_ram #(
  parameter int DEPTH = 256,
  parameter int WIDTH = 16,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             i_we,
  input  logic [AW-1:0]    i_waddr,
  input  logic [WIDTH-1:0] i_wdata,
  input  logic [AW-1:0]    i_raddr,
  output logic [WIDTH-1:0] o_rdata
);

  logic [WIDTH-1:0] r_mem [DEPTH];

  always_ff @(posedge clk) begin
    if (i_we) r_mem[i_waddr] <= i_wdata;
    o_rdata <= r_mem[i_raddr];
  end

endmodule

// File: rtl/dso_trig_capture.sv
// Multi-channel edge-trigger capture: ring-buffered pre-history, post-trigger
// frames, packed into OUT_W words on a valid/ready stream.
module dso_trig_capture
  import dso_cap_pkg::*;
#(
  parameter int CH_NUM    = 2,
  parameter int SMP_W     = 8,
  parameter int PRE_DEPTH = 256,
  parameter int CAP_LEN_W = 16,
  parameter int OUT_W     = 32,
  localparam int FRM_W    = CH_NUM * SMP_W,
  localparam int PRE_W    = $clog2(PRE_DEPTH),
  localparam int TCH_W    = (CH_NUM > 1) ? $clog2(CH_NUM) : 1
) (
  input  logic                 ad_clk,
  input  logic                 sys_rst_n,
  input  logic [FRM_W-1:0]     ad_data,
  input  logic                 arm,
  input  logic                 abort,
  input  logic [TCH_W-1:0]     trig_ch,
  input  logic [1:0]           trig_mode,
  input  logic [SMP_W-1:0]     trig_level,
  input  logic [PRE_W-1:0]     pre_len,
  input  logic [CAP_LEN_W-1:0] cap_len,
  output logic [OUT_W-1:0]     m_data,
  output logic                 m_valid,
  input  logic                 m_ready,
  output logic                 busy,
  output logic                 triggered,
  output logic                 done,
  output logic                 overflow
);

  localparam int PACK   = calc_pack(OUT_W, CH_NUM, SMP_W);
  localparam int SLOT_W = (PACK > 1) ? $clog2(PACK) : 1;
  localparam int TOT_W  = ((PRE_W > CAP_LEN_W) ? PRE_W : CAP_LEN_W) + 1;

  cap_state_t           r_state;
  logic [PRE_W-1:0]     r_wr_ptr;
  logic [FRM_W-1:0]     r_din;
  logic [FRM_W-1:0]     r_din_d;
  logic [TCH_W-1:0]     r_trig_ch_q;
  logic [1:0]           r_mode_q;
  logic [SMP_W-1:0]     r_level_q;
  logic [PRE_W-1:0]     r_pre_q;
  logic [TOT_W-1:0]     r_total;
  logic [TOT_W-1:0]     r_cnt;
  logic [SLOT_W-1:0]    r_slot;
  logic [OUT_W-1:0]     r_pack;
  logic                 r_pv0;
  logic                 r_pvld;

  logic [PRE_W-1:0]     w_raddr;
  logic [FRM_W-1:0]     w_rdata;
  logic [FRM_W-1:0]     w_dly;
  logic [SMP_W-1:0]     w_c;
  logic [SMP_W-1:0]     w_p;
  logic                 w_rise;
  logic                 w_fall;
  logic                 w_trig;
  logic                 w_frm_last;
  logic                 w_word_last;
  logic [OUT_W-1:0]     w_word;
  logic [TOT_W-1:0]     w_total_in;

  // Stage 0: input frame register and its one-cycle-delayed copy
  always_ff @(posedge ad_clk) begin
    r_din   <= ad_data;
    r_din_d <= r_din;
  end

  always_ff @(posedge ad_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) r_wr_ptr <= '0;
    else            r_wr_ptr <= r_wr_ptr + 1'b1;
  end

  assign w_raddr = r_wr_ptr - r_pre_q;

  dso_ring_ram #(
    .DEPTH (PRE_DEPTH),
    .WIDTH (FRM_W)
  ) u_ring (
    .clk     (ad_clk),
    .i_we    (1'b1),
    .i_waddr (r_wr_ptr),
    .i_wdata (r_din),
    .i_raddr (w_raddr),
    .o_rdata (w_rdata)
  );

  // Stage 1: delayed stream; a zero delay would read the slot being written, so bypass the RAM
  assign w_dly = (r_pre_q == '0) ? r_din_d : w_rdata;

  always_comb begin
    w_c = '0;
    w_p = '0;
    for (int i = 0; i < CH_NUM; i++) begin
      if (TCH_W'(i) == r_trig_ch_q) begin
        w_c = r_din[i*SMP_W +: SMP_W];
        w_p = r_din_d[i*SMP_W +: SMP_W];
      end
    end
  end

  assign w_rise = r_pvld && (w_p < r_level_q) && (w_c >= r_level_q);
  assign w_fall = r_pvld && (w_p >= r_level_q) && (w_c < r_level_q);

  always_comb begin
    case (r_mode_q)
      TRIG_RISE: w_trig = w_rise;
      TRIG_FALL: w_trig = w_fall;
      TRIG_BOTH: w_trig = w_rise || w_fall;
      default:   w_trig = 1'b1;
    endcase
  end

  always_comb begin
    w_word = r_pack;
    w_word[r_slot*FRM_W +: FRM_W] = w_dly;
  end

  assign w_frm_last  = (r_cnt == r_total - 1'b1);
  assign w_word_last = w_frm_last || (r_slot == SLOT_W'(PACK - 1));
  assign w_total_in  = TOT_W'(pre_len) + ((cap_len == '0) ? TOT_W'(1) : TOT_W'(cap_len));

  // Stage 2: control FSM, packer and output register
  always_ff @(posedge ad_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      r_state     <= ST_IDLE;
      r_trig_ch_q <= '0;
      r_mode_q    <= TRIG_RISE;
      r_level_q   <= '0;
      r_pre_q     <= '0;
      r_total     <= '0;
      r_cnt       <= '0;
      r_slot      <= '0;
      r_pack      <= '0;
      r_pv0       <= 1'b0;
      r_pvld      <= 1'b0;
      m_data      <= '0;
      m_valid     <= 1'b0;
      busy        <= 1'b0;
      triggered   <= 1'b0;
      done        <= 1'b0;
      overflow    <= 1'b0;
    end else begin
      done <= 1'b0;
      if (m_valid && m_ready) m_valid <= 1'b0;
      // previous-sample qualifier: only frames that arrived after arm count
      r_pv0  <= (r_state != ST_IDLE);
      r_pvld <= r_pv0 && (r_state != ST_IDLE);
      if (abort) begin
        r_state   <= ST_IDLE;
        m_valid   <= 1'b0;
        r_slot    <= '0;
        r_pack    <= '0;
        r_cnt     <= '0;
        triggered <= 1'b0;
        busy      <= 1'b0;
        r_pv0     <= 1'b0;
        r_pvld    <= 1'b0;
      end else begin
        case (r_state)
          ST_IDLE: begin
            if (arm) begin
              r_trig_ch_q <= trig_ch;
              r_mode_q    <= trig_mode;
              r_level_q   <= trig_level;
              r_pre_q     <= pre_len;
              r_total     <= w_total_in;
              r_cnt       <= '0;
              r_slot      <= '0;
              r_pack      <= '0;
              overflow    <= 1'b0;
              busy        <= 1'b1;
              r_state     <= ST_FILL;
            end
          end
          ST_FILL: begin
            if (r_cnt == TOT_W'(r_pre_q)) begin
              r_cnt   <= '0;
              r_state <= ST_WAIT;
            end else begin
              r_cnt <= r_cnt + 1'b1;
            end
          end
          ST_WAIT: begin
            if (w_trig) begin
              triggered <= 1'b1;
              r_cnt     <= '0;
              r_state   <= ST_POST;
            end
          end
          ST_POST: begin
            if (w_word_last) begin
              r_pack <= '0;
              r_slot <= '0;
              if (m_valid && !m_ready) begin
                overflow <= 1'b1;
              end else begin
                m_valid <= 1'b1;
                m_data  <= w_word;
              end
            end else begin
              r_pack <= w_word;
              r_slot <= r_slot + 1'b1;
            end
            if (w_frm_last) begin
              r_cnt   <= '0;
              r_state <= ST_FLUSH;
            end else begin
              r_cnt <= r_cnt + 1'b1;
            end
          end
          ST_FLUSH: begin
            if (!m_valid || m_ready) begin
              done      <= 1'b1;
              busy      <= 1'b0;
              triggered <= 1'b0;
              r_state   <= ST_IDLE;
            end
          end
          default: r_state <= ST_IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_dso_trig_capture.sv
// Scoreboard bench for dso_trig_capture, single 8-bit channel packed into 32-bit words.
module tb_dso_trig_capture;
  import dso_cap_pkg::*;

  logic        ad_clk;
  logic        sys_rst_n;
  logic [7:0]  ad_data;
  logic        arm;
  logic        abort;
  logic [0:0]  trig_ch;
  logic [1:0]  trig_mode;
  logic [7:0]  trig_level;
  logic [7:0]  pre_len;
  logic [15:0] cap_len;
  logic [31:0] m_data;
  logic        m_valid;
  logic        m_ready;
  logic        busy;
  logic        triggered;
  logic        done;
  logic        overflow;

  int checks = 0;
  int failures = 0;
  int smp_idx = 0;
  int pattern = 0;
  int rdy_lo_start = 0;
  int rdy_lo_len = 0;
  int first_vld_idx = -1;
  int trig_idx = -1;
  int done_cnt = 0;
  int done_busy_bad = 0;
  int hold_bad = 0;
  bit hold_armed = 0;
  logic [31:0] hold_data = '0;
  logic [31:0] exp_q[$];
  logic [31:0] got_q[$];

  dso_trig_capture #(
    .CH_NUM(1), .SMP_W(8), .PRE_DEPTH(256), .CAP_LEN_W(16), .OUT_W(32)
  ) dut (
    .ad_clk(ad_clk), .sys_rst_n(sys_rst_n), .ad_data(ad_data), .arm(arm), .abort(abort),
    .trig_ch(trig_ch), .trig_mode(trig_mode), .trig_level(trig_level), .pre_len(pre_len),
    .cap_len(cap_len), .m_data(m_data), .m_valid(m_valid), .m_ready(m_ready), .busy(busy),
    .triggered(triggered), .done(done), .overflow(overflow)
  );

  initial ad_clk = 1'b0;
  always #5 ad_clk = ~ad_clk;

  function automatic logic [7:0] gen(input int i);
    if (pattern == 1) return ((i >= 3 && i < 6) || i >= 12) ? 8'd200 : 8'd10;
    return 8'(i % 256);
  endfunction

  // Called at a falling edge: drive cycle smp_idx, observe outputs of that cycle, advance.
  task automatic tick();
    ad_data = gen(smp_idx);
    m_ready = !(rdy_lo_len > 0 && smp_idx >= rdy_lo_start && smp_idx < rdy_lo_start + rdy_lo_len);
    if (m_valid && first_vld_idx < 0) first_vld_idx = smp_idx;
    if (m_valid && m_ready) got_q.push_back(m_data);
    if (triggered && trig_idx < 0) trig_idx = smp_idx;
    if (done) begin
      done_cnt++;
      if (busy) done_busy_bad++;
    end
    if (hold_armed && (!m_valid || m_data !== hold_data)) hold_bad++;
    hold_armed = m_valid && !m_ready && !abort;
    hold_data  = m_data;
    smp_idx++;
    @(posedge ad_clk);
    @(negedge ad_clk);
  endtask

  task automatic start_capture(input logic [1:0] mode, input logic [7:0] lvl, input int pre,
                               input int cap, input int pat);
    int trig;
    int total;
    int slot;
    logic [7:0] p, c;
    logic [31:0] word;
    bit r, f;
    pattern = pat;
    exp_q.delete();
    got_q.delete();
    trig = -1;
    for (int j = pre + 1; j < pre + 2000 && trig < 0; j++) begin
      if (mode == TRIG_FORCE) trig = j;
      else if (j >= 2) begin
        p = gen(j - 1);
        c = gen(j);
        r = (p < lvl) && (c >= lvl);
        f = (p >= lvl) && (c < lvl);
        if ((mode == TRIG_RISE && r) || (mode == TRIG_FALL && f) || (mode == TRIG_BOTH && (r || f)))
          trig = j;
      end
    end
    total = pre + ((cap == 0) ? 1 : cap);
    word = '0;
    slot = 0;
    for (int k = 0; k < total; k++) begin
      word[slot*8 +: 8] = gen(trig - pre + k);
      slot++;
      if (slot == 4 || k == total - 1) begin
        exp_q.push_back(word);
        word = '0;
        slot = 0;
      end
    end
    trig_mode = mode;
    trig_level = lvl;
    pre_len = 8'(pre);
    cap_len = 16'(cap);
    trig_ch = 1'b0;
    smp_idx = 0;
    first_vld_idx = -1;
    trig_idx = -1;
    done_cnt = 0;
    done_busy_bad = 0;
    hold_bad = 0;
    arm = 1'b1;
    tick();
    arm = 1'b0;
  endtask

  task automatic wait_done(input int budget, output bit timed_out);
    int n;
    n = 0;
    while (done_cnt == 0 && n < budget) begin
      tick();
      n++;
    end
    timed_out = (done_cnt == 0);
    repeat (2) tick();
  endtask

  task automatic test_reset();
    sys_rst_n = 1'b0;
    #1;
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL rst_busy got=%b exp=0", busy); end
    checks++; if (m_valid !== 1'b0) begin failures++; $display("FAIL rst_m_valid got=%b exp=0", m_valid); end
    checks++; if (m_data !== 32'h0) begin failures++; $display("FAIL rst_m_data got=%h exp=0", m_data); end
    checks++; if (triggered !== 1'b0) begin failures++; $display("FAIL rst_triggered got=%b exp=0", triggered); end
    checks++; if (done !== 1'b0 || overflow !== 1'b0) begin
      failures++; $display("FAIL rst_done_ovf got=%b/%b exp=0/0", done, overflow);
    end
    @(negedge ad_clk);
    tick();
    sys_rst_n = 1'b1;
    repeat (3) tick();
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL idle_busy got=%b exp=0", busy); end
  endtask

  task automatic test_rising();
    bit to;
    logic [31:0] e, g;
    start_capture(TRIG_RISE, 8'd100, 4, 8, 0);
    wait_done(400, to);
    checks++; if (to) begin failures++; $display("FAIL rise_timeout done not seen"); end
    checks++; if (trig_idx != 102) begin failures++; $display("FAIL rise_trig_latency got=%0d exp=102", trig_idx); end
    checks++; if (first_vld_idx != 106) begin failures++; $display("FAIL rise_out_latency got=%0d exp=106", first_vld_idx); end
    checks++; if (done_cnt != 1) begin failures++; $display("FAIL rise_done_count got=%0d exp=1", done_cnt); end
    checks++; if (done_busy_bad != 0) begin failures++; $display("FAIL rise_busy_at_done got=%0d exp=0", done_busy_bad); end
    checks++; if (got_q.size() != 3) begin failures++; $display("FAIL rise_words got=%0d exp=3", got_q.size()); end
    checks++; if (got_q.size() < 1 || got_q[0] !== 32'h63626160) begin
      failures++; $display("FAIL rise_word0 got=%h exp=63626160", (got_q.size() > 0) ? got_q[0] : 32'hx);
    end
    while (exp_q.size() > 0 && got_q.size() > 0) begin
      e = exp_q.pop_front(); g = got_q.pop_front();
      checks++; if (g !== e) begin failures++; $display("FAIL rise_word got=%h exp=%h", g, e); end
    end
  endtask

  task automatic test_falling();
    bit to;
    logic [31:0] e, g;
    start_capture(TRIG_FALL, 8'd100, 4, 8, 0);
    wait_done(800, to);
    checks++; if (to) begin failures++; $display("FAIL fall_timeout done not seen"); end
    checks++; if (trig_idx != 258) begin failures++; $display("FAIL fall_trig_latency got=%0d exp=258", trig_idx); end
    checks++; if (got_q.size() < 1 || got_q[0] !== 32'hFFFEFDFC) begin
      failures++; $display("FAIL fall_word0 got=%h exp=fffefdfc", (got_q.size() > 0) ? got_q[0] : 32'hx);
    end
    checks++; if (got_q.size() != exp_q.size()) begin
      failures++; $display("FAIL fall_words got=%0d exp=%0d", got_q.size(), exp_q.size());
    end
    while (exp_q.size() > 0 && got_q.size() > 0) begin
      e = exp_q.pop_front(); g = got_q.pop_front();
      checks++; if (g !== e) begin failures++; $display("FAIL fall_word got=%h exp=%h", g, e); end
    end
  endtask

  task automatic test_force_partial();
    bit to;
    logic [31:0] e, g;
    start_capture(TRIG_FORCE, 8'd0, 0, 9, 0);
    wait_done(100, to);
    checks++; if (to) begin failures++; $display("FAIL force_timeout done not seen"); end
    checks++; if (got_q.size() != 3) begin failures++; $display("FAIL force_words got=%0d exp=3", got_q.size()); end
    checks++; if (got_q.size() < 3 || got_q[2] !== 32'h00000009) begin
      failures++; $display("FAIL force_pad_word got=%h exp=00000009", (got_q.size() > 2) ? got_q[2] : 32'hx);
    end
    while (exp_q.size() > 0 && got_q.size() > 0) begin
      e = exp_q.pop_front(); g = got_q.pop_front();
      checks++; if (g !== e) begin failures++; $display("FAIL force_word got=%h exp=%h", g, e); end
    end
  endtask

  task automatic test_overflow();
    bit to;
    int drops, delivered;
    logic [31:0] g;
    rdy_lo_start = 112;
    rdy_lo_len = 10;
    start_capture(TRIG_RISE, 8'd100, 4, 44, 0);
    wait_done(400, to);
    rdy_lo_len = 0;
    checks++; if (to) begin failures++; $display("FAIL ovf_timeout done not seen"); end
    checks++; if (overflow !== 1'b1) begin failures++; $display("FAIL ovf_flag got=%b exp=1", overflow); end
    checks++; if (hold_bad != 0) begin failures++; $display("FAIL ovf_hold_stable got=%0d exp=0", hold_bad); end
    delivered = got_q.size();
    drops = 0;
    while (got_q.size() > 0) begin
      g = got_q.pop_front();
      while (exp_q.size() > 0 && exp_q[0] !== g) begin
        void'(exp_q.pop_front());
        drops++;
      end
      checks++;
      if (exp_q.size() == 0) begin failures++; $display("FAIL ovf_word got=%h exp=in-order capture word", g); end
      else void'(exp_q.pop_front());
    end
    drops += exp_q.size();
    checks++; if (delivered != 10) begin failures++; $display("FAIL ovf_delivered got=%0d exp=10", delivered); end
    checks++; if (delivered + drops != 12) begin
      failures++; $display("FAIL ovf_total got=%0d exp=12", delivered + drops);
    end
    start_capture(TRIG_RISE, 8'd100, 4, 8, 0);
    checks++; if (overflow !== 1'b0) begin failures++; $display("FAIL ovf_clear_on_arm got=%b exp=0", overflow); end
    wait_done(400, to);
    checks++; if (to) begin failures++; $display("FAIL ovf_rearm_timeout done not seen"); end
  endtask

  task automatic test_fill_crossing();
    bit to;
    logic [31:0] e, g;
    start_capture(TRIG_RISE, 8'd100, 8, 4, 1);
    wait_done(200, to);
    checks++; if (to) begin failures++; $display("FAIL fill_timeout done not seen"); end
    checks++; if (trig_idx != 14) begin failures++; $display("FAIL fill_trig_latency got=%0d exp=14", trig_idx); end
    checks++; if (got_q.size() < 1 || got_q[0] !== 32'h0A0AC8C8) begin
      failures++; $display("FAIL fill_word0 got=%h exp=0a0ac8c8", (got_q.size() > 0) ? got_q[0] : 32'hx);
    end
    checks++; if (got_q.size() != exp_q.size()) begin
      failures++; $display("FAIL fill_words got=%0d exp=%0d", got_q.size(), exp_q.size());
    end
    while (exp_q.size() > 0 && got_q.size() > 0) begin
      e = exp_q.pop_front(); g = got_q.pop_front();
      checks++; if (g !== e) begin failures++; $display("FAIL fill_word got=%h exp=%h", g, e); end
    end
  endtask

  task automatic test_reset_in_post();
    bit to;
    logic [31:0] e, g;
    start_capture(TRIG_RISE, 8'd100, 4, 8, 0);
    while (trig_idx < 0 && smp_idx < 400) tick();
    checks++; if (trig_idx < 0) begin failures++; $display("FAIL rpost_trigger got=none exp=trigger"); end
    repeat (5) tick();
    sys_rst_n = 1'b0;
    #1;
    checks++; if (busy !== 1'b0 || triggered !== 1'b0) begin
      failures++; $display("FAIL rpost_busy_trig got=%b/%b exp=0/0", busy, triggered);
    end
    checks++; if (m_valid !== 1'b0 || m_data !== 32'h0) begin
      failures++; $display("FAIL rpost_output got=%b/%h exp=0/0", m_valid, m_data);
    end
    checks++; if (done !== 1'b0 || overflow !== 1'b0) begin
      failures++; $display("FAIL rpost_done_ovf got=%b/%b exp=0/0", done, overflow);
    end
    hold_armed = 0;
    @(negedge ad_clk);
    tick();
    sys_rst_n = 1'b1;
    tick();
    start_capture(TRIG_RISE, 8'd100, 4, 8, 0);
    wait_done(400, to);
    checks++; if (to) begin failures++; $display("FAIL rpost_rearm_timeout done not seen"); end
    checks++; if (got_q.size() != 3) begin failures++; $display("FAIL rpost_words got=%0d exp=3", got_q.size()); end
    while (exp_q.size() > 0 && got_q.size() > 0) begin
      e = exp_q.pop_front(); g = got_q.pop_front();
      checks++; if (g !== e) begin failures++; $display("FAIL rpost_word got=%h exp=%h", g, e); end
    end
  endtask

  task automatic test_abort();
    bit to;
    logic [31:0] e, g;
    rdy_lo_start = 100;
    rdy_lo_len = 100;
    start_capture(TRIG_RISE, 8'd100, 4, 44, 0);
    while (smp_idx < 109) tick();
    checks++; if (m_valid !== 1'b1) begin failures++; $display("FAIL abort_pre_valid got=%b exp=1", m_valid); end
    abort = 1'b1;
    tick();
    abort = 1'b0;
    checks++; if (busy !== 1'b0 || triggered !== 1'b0) begin
      failures++; $display("FAIL abort_idle got=%b/%b exp=0/0", busy, triggered);
    end
    checks++; if (m_valid !== 1'b0) begin failures++; $display("FAIL abort_m_valid got=%b exp=0", m_valid); end
    arm = 1'b1;
    abort = 1'b1;
    tick();
    arm = 1'b0;
    abort = 1'b0;
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL abort_wins_over_arm got=%b exp=0", busy); end
    rdy_lo_len = 0;
    start_capture(TRIG_RISE, 8'd100, 4, 8, 0);
    wait_done(400, to);
    checks++; if (to) begin failures++; $display("FAIL abort_rearm_timeout done not seen"); end
    checks++; if (got_q.size() != 3) begin failures++; $display("FAIL abort_words got=%0d exp=3", got_q.size()); end
    while (exp_q.size() > 0 && got_q.size() > 0) begin
      e = exp_q.pop_front(); g = got_q.pop_front();
      checks++; if (g !== e) begin failures++; $display("FAIL abort_word got=%h exp=%h", g, e); end
    end
  endtask

  initial begin
    sys_rst_n = 1'b0;
    ad_data = '0;
    arm = 1'b0;
    abort = 1'b0;
    trig_ch = '0;
    trig_mode = TRIG_RISE;
    trig_level = '0;
    pre_len = '0;
    cap_len = '0;
    m_ready = 1'b1;
    @(negedge ad_clk);
    test_reset();
    test_rising();
    test_falling();
    test_force_partial();
    test_overflow();
    test_fill_crossing();
    test_reset_in_post();
    test_abort();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
